// File: rtl/ir_bank_loader_buffer.sv
// ir_bank_loader_buffer
// Impulse-response store for the convolution engine. IR samples stream in
// time order and are written time-reversed across NUM_BANKS dual-port RAMs.
// Once the IR is resident, every bank serves two taps per cycle through a
// 2-cycle registered read path with a valid flag.
module ir_bank_loader_buffer #(
  parameter  int SAMPLE_WIDTH = 16,
  parameter  int IR_LENGTH    = 24000,
  parameter  int NUM_BANKS    = 4,
  localparam int DEPTH        = IR_LENGTH / NUM_BANKS,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                                       audio_clk,
  input  logic                                       rst_in,
  input  logic                                       load_start,
  input  logic signed [SAMPLE_WIDTH-1:0]             s_data,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  output logic                                       load_done,
  output logic                                       ir_loaded,
  input  logic                                       rd_valid,
  input  logic        [AW-1:0]                       rd_addr_a,
  input  logic        [AW-1:0]                       rd_addr_b,
  output logic signed [2*NUM_BANKS*SAMPLE_WIDTH-1:0] ir_vals,
  output logic                                       ir_valid
);

  localparam int            BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int            LW        = 2 * NUM_BANKS * SAMPLE_WIDTH;
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] TOP_OFF   = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic   [BW-1:0]                 bank_q, bank_d;
  logic   [AW-1:0]                 off_q, off_d;
  logic                            load_done_q, load_done_d;
  logic                            ir_loaded_q, ir_loaded_d;
  logic                            loading_s, accept_s, last_s, rd_acc_s;
  logic                            rd1_q, oor_a_q, oor_b_q;
  logic   [NUM_BANKS*SAMPLE_WIDTH-1:0] ram_a_s, ram_b_s;
  logic   [LW-1:0]                 ir_vals_q, ir_vals_d;
  logic                            ir_valid_q;

  // load_start wins over a same-cycle sample, so ready drops while it is seen
  assign loading_s = (state_q == LOADING);
  assign s_ready   = loading_s && !load_start;
  assign accept_s  = s_valid && s_ready;
  assign last_s    = (bank_q == '0) && (off_q == '0);
  assign rd_acc_s  = rd_valid && (state_q == READY);

  // Next-state logic: FSM, bank counter and offset down-counter
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    off_d       = off_q;
    load_done_d = 1'b0;
    ir_loaded_d = ir_loaded_q;
    if (load_start) begin
      // index 0 lands in the last bank at its top address
      state_d     = LOADING;
      bank_d      = LAST_BANK;
      off_d       = TOP_OFF;
      ir_loaded_d = 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        state_d     = READY;
        load_done_d = 1'b1;
        ir_loaded_d = 1'b1;
      end else if (off_q == '0) begin
        off_d  = TOP_OFF;
        bank_d = bank_q - 1'b1;
      end else begin
        off_d = off_q - 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q     <= EMPTY;
      bank_q      <= '0;
      off_q       <= '0;
      load_done_q <= 1'b0;
      ir_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      off_q       <= off_d;
      load_done_q <= load_done_d;
      ir_loaded_q <= ir_loaded_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
    logic [SAMPLE_WIDTH-1:0] rda_q, rdb_q;
    logic [AW-1:0]           addr_a_s;
    logic                    we_s;

    assign we_s     = accept_s && (bank_q == BW'(b));
    assign addr_a_s = loading_s ? off_q : rd_addr_a;

    // Bank RAM: port A write/read, port B read-only; contents survive reset
    always_ff @(posedge audio_clk) begin
      if (we_s) begin
        mem_q[addr_a_s] <= s_data;
      end
      rda_q <= mem_q[addr_a_s];
      rdb_q <= mem_q[rd_addr_b];
    end

    assign ram_a_s[b*SAMPLE_WIDTH +: SAMPLE_WIDTH] = rda_q;
    assign ram_b_s[b*SAMPLE_WIDTH +: SAMPLE_WIDTH] = rdb_q;
  end

  // First read stage: valid and out-of-range flags ride alongside RAM output
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      rd1_q   <= 1'b0;
      oor_a_q <= 1'b0;
      oor_b_q <= 1'b0;
    end else begin
      rd1_q   <= rd_acc_s;
      oor_a_q <= ({1'b0, rd_addr_a} >= DEPTH_W);
      oor_b_q <= ({1'b0, rd_addr_b} >= DEPTH_W);
    end
  end

  // Lane assembly: out-of-range lanes read as zero, hold when nothing completes
  always_comb begin
    ir_vals_d = ir_vals_q;
    if (rd1_q) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ir_vals_d[(2*b)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
          oor_a_q ? '0 : ram_a_s[b*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        ir_vals_d[(2*b+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
          oor_b_q ? '0 : ram_b_s[b*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end else begin
      ir_vals_d = ir_vals_q;
    end
  end

  // Second read stage: registered lanes and valid, squashed by reset
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      ir_vals_q  <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_vals_q  <= ir_vals_d;
      ir_valid_q <= rd1_q;
    end
  end

  assign load_done = load_done_q;
  assign ir_loaded = ir_loaded_q;
  assign ir_vals   = ir_vals_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_ir_bank_loader_buffer.sv
// Directed bench for ir_bank_loader_buffer. The main instance uses the
// 16-sample / 4-bank configuration; a second instance with DEPTH=5 gives
// the address ports room to express out-of-range addresses.
module tb_ir_bank_loader_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld = 1'b0, sval = 1'b0, rv = 1'b0;
  logic [15:0]  sdat = 16'd0;
  logic [1:0]   ra = 2'd0, rb = 2'd0;
  logic         srdy, ldone, iload, ivld;
  logic [127:0] ivals;

  logic         ld5 = 1'b0, sval5 = 1'b0, rv5 = 1'b0;
  logic [15:0]  sdat5 = 16'd0;
  logic [2:0]   ra5 = 3'd0, rb5 = 3'd0;
  logic         srdy5, ldone5, iload5, ivld5;
  logic [127:0] ivals5;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] last_vec;

  always #5 clk = ~clk;

  ir_bank_loader_buffer #(.SAMPLE_WIDTH(16), .IR_LENGTH(16), .NUM_BANKS(4)) dut (
    .audio_clk(clk), .rst_in(rst), .load_start(ld), .s_data(sdat), .s_valid(sval),
    .s_ready(srdy), .load_done(ldone), .ir_loaded(iload), .rd_valid(rv),
    .rd_addr_a(ra), .rd_addr_b(rb), .ir_vals(ivals), .ir_valid(ivld));

  ir_bank_loader_buffer #(.SAMPLE_WIDTH(16), .IR_LENGTH(20), .NUM_BANKS(4)) dut5 (
    .audio_clk(clk), .rst_in(rst), .load_start(ld5), .s_data(sdat5), .s_valid(sval5),
    .s_ready(srdy5), .load_done(ldone5), .ir_loaded(iload5), .rd_valid(rv5),
    .rd_addr_a(ra5), .rd_addr_b(rb5), .ir_vals(ivals5), .ir_valid(ivld5));

  // Inverse of the load mapping for DEPTH=4: bank b, address x holds index 4*(3-b)+(3-x)
  function automatic logic [127:0] exp_vec(input int base, input int aa, input int bb);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      v[(2*b)*16   +: 16] = 16'(base + 4*(3-b) + (3-aa));
      v[(2*b+1)*16 +: 16] = 16'(base + 4*(3-b) + (3-bb));
    end
    return v;
  endfunction

  // Same for DEPTH=5, with out-of-range addresses reading as zero
  function automatic logic [127:0] exp5(input int aa, input int bb);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      v[(2*b)*16   +: 16] = (aa > 4) ? 16'd0 : 16'(5*(3-b) + (4-aa));
      v[(2*b+1)*16 +: 16] = (bb > 4) ? 16'd0 : 16'(5*(3-b) + (4-bb));
    end
    return v;
  endfunction

  // Stimulus only: pulse load_start (with a sample that must be dropped), then stream n samples
  task automatic drive_load(input int base, input bit gaps, input int n,
                            output int rdy_cyc, output int early_done, output int rdy_at_start);
    int acc;
    int cyc;
    acc = 0; cyc = 0; rdy_cyc = 0; early_done = 0;
    @(negedge clk);
    ld = 1'b1; sval = 1'b1; sdat = 16'hDEAD;
    #1;
    rdy_at_start = int'(srdy);
    @(negedge clk);
    ld = 1'b0;
    while (acc < n && cyc < 100) begin
      sval = gaps ? ((cyc % 2) == 0) : 1'b1;
      sdat = 16'(base + acc);
      #1;
      if (srdy) rdy_cyc++;
      if (ldone) early_done++;
      if (srdy && sval) acc++;
      cyc++;
      @(negedge clk);
    end
    sval = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (srdy !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %0b want 0", srdy); end
    n_cmp++; if (ldone !== 1'b0) begin n_bad++; $display("FAIL reset_load_done: got %0b want 0", ldone); end
    n_cmp++; if (iload !== 1'b0) begin n_bad++; $display("FAIL reset_ir_loaded: got %0b want 0", iload); end
    n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL reset_ir_valid: got %0b want 0", ivld); end
    n_cmp++; if (ivals !== 128'd0) begin n_bad++; $display("FAIL reset_ir_vals: got %h want 0", ivals); end
    rst = 1'b0;
  endtask

  task automatic test_reads_blocked_empty();
    rv = 1'b1; ra = 2'd3; rb = 2'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL empty_read_valid: got %0b want 0", ivld); end
      n_cmp++; if (ivals !== 128'd0) begin n_bad++; $display("FAIL empty_read_vals: got %h want 0", ivals); end
    end
    rv = 1'b0;
  endtask

  task automatic test_full_load();
    int rc, ed, rs;
    drive_load(0, 1'b0, 16, rc, ed, rs);
    n_cmp++; if (rc !== 16) begin n_bad++; $display("FAIL full_ready_cycles: got %0d want 16", rc); end
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL full_early_done: got %0d want 0", ed); end
    n_cmp++; if (ldone !== 1'b1) begin n_bad++; $display("FAIL full_load_done: got %0b want 1", ldone); end
    n_cmp++; if (iload !== 1'b1) begin n_bad++; $display("FAIL full_ir_loaded: got %0b want 1", iload); end
    n_cmp++; if (srdy !== 1'b0) begin n_bad++; $display("FAIL full_ready_after: got %0b want 0", srdy); end
    // first read issued on the load_done cycle
    rv = 1'b1; ra = 2'd3; rb = 2'd0;
    @(negedge clk);
    rv = 1'b0;
    n_cmp++; if (ldone !== 1'b0) begin n_bad++; $display("FAIL full_done_pulse: got %0b want 0", ldone); end
    n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL full_read_early: got %0b want 0", ivld); end
    @(negedge clk);
    last_vec = exp_vec(0, 3, 0);
    n_cmp++; if (ivld !== 1'b1) begin n_bad++; $display("FAIL full_read_valid: got %0b want 1", ivld); end
    n_cmp++; if (ivals !== last_vec) begin n_bad++; $display("FAIL full_read_vals: got %h want %h", ivals, last_vec); end
    @(negedge clk);
    n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL full_read_single: got %0b want 0", ivld); end
    n_cmp++; if (ivals !== last_vec) begin n_bad++; $display("FAIL full_read_hold: got %h want %h", ivals, last_vec); end
  endtask

  task automatic test_reads_blocked_loading();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; rv = 1'b1; ra = 2'd1; rb = 2'd2;
    n_cmp++; if (iload !== 1'b0) begin n_bad++; $display("FAIL load_clears_ir_loaded: got %0b want 0", iload); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL loading_read_valid: got %0b want 0", ivld); end
      n_cmp++; if (ivals !== last_vec) begin n_bad++; $display("FAIL loading_read_vals: got %h want %h", ivals, last_vec); end
    end
    rv = 1'b0;
  endtask

  task automatic test_gaps();
    int rc, ed, rs;
    drive_load(50, 1'b1, 16, rc, ed, rs);
    n_cmp++; if (rc !== 31) begin n_bad++; $display("FAIL gaps_ready_cycles: got %0d want 31", rc); end
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL gaps_early_done: got %0d want 0", ed); end
    n_cmp++; if (ldone !== 1'b1) begin n_bad++; $display("FAIL gaps_load_done: got %0b want 1", ldone); end
    rv = 1'b1; ra = 2'd1; rb = 2'd2;
    @(negedge clk);
    rv = 1'b0;
    @(negedge clk);
    last_vec = exp_vec(50, 1, 2);
    n_cmp++; if (ivld !== 1'b1) begin n_bad++; $display("FAIL gaps_read_valid: got %0b want 1", ivld); end
    n_cmp++; if (ivals !== last_vec) begin n_bad++; $display("FAIL gaps_read_vals: got %h want %h", ivals, last_vec); end
  endtask

  task automatic test_restart();
    int rc, ed, rs;
    drive_load(200, 1'b0, 7, rc, ed, rs);
    n_cmp++; if (ldone !== 1'b0) begin n_bad++; $display("FAIL restart_partial_done: got %0b want 0", ldone); end
    n_cmp++; if (srdy !== 1'b1) begin n_bad++; $display("FAIL restart_partial_ready: got %0b want 1", srdy); end
    drive_load(100, 1'b0, 16, rc, ed, rs);
    n_cmp++; if (rs !== 0) begin n_bad++; $display("FAIL restart_ready_on_start: got %0d want 0", rs); end
    n_cmp++; if (rc !== 16) begin n_bad++; $display("FAIL restart_ready_cycles: got %0d want 16", rc); end
    n_cmp++; if (ed !== 0) begin n_bad++; $display("FAIL restart_early_done: got %0d want 0", ed); end
    n_cmp++; if (ldone !== 1'b1) begin n_bad++; $display("FAIL restart_load_done: got %0b want 1", ldone); end
    rv = 1'b1; ra = 2'd3; rb = 2'd3;
    @(negedge clk);
    rv = 1'b0;
    @(negedge clk);
    last_vec = exp_vec(100, 3, 3);
    n_cmp++; if (ivals !== last_vec) begin n_bad++; $display("FAIL restart_read_vals: got %h want %h", ivals, last_vec); end
  endtask

  task automatic test_stream();
    logic [127:0] e;
    for (int c = 0; c < 6; c++) begin
      rv = (c < 4); ra = 2'(c); rb = 2'(3 - c);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        e = exp_vec(100, c - 1, 4 - c);
        n_cmp++; if (ivld !== 1'b1) begin n_bad++; $display("FAIL stream_valid_%0d: got %0b want 1", c, ivld); end
        n_cmp++; if (ivals !== e) begin n_bad++; $display("FAIL stream_vals_%0d: got %h want %h", c, ivals, e); end
      end else begin
        n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL stream_idle_%0d: got %0b want 0", c, ivld); end
      end
    end
    rv = 1'b0;
  endtask

  task automatic test_out_of_range();
    int sa[6] = '{0, 1, 2, 3, 4, 5};
    int sb[6] = '{4, 3, 2, 1, 0, 6};
    logic [127:0] e;
    @(negedge clk);
    ld5 = 1'b1;
    @(negedge clk);
    ld5 = 1'b0; sval5 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sdat5 = 16'(i);
      @(negedge clk);
    end
    sval5 = 1'b0;
    n_cmp++; if (ldone5 !== 1'b1) begin n_bad++; $display("FAIL oor_load_done: got %0b want 1", ldone5); end
    for (int c = 0; c < 8; c++) begin
      rv5 = (c < 6);
      ra5 = (c < 6) ? 3'(sa[c]) : 3'd0;
      rb5 = (c < 6) ? 3'(sb[c]) : 3'd0;
      @(negedge clk);
      if (c >= 1 && c <= 6) begin
        e = exp5(sa[c-1], sb[c-1]);
        n_cmp++; if (ivld5 !== 1'b1) begin n_bad++; $display("FAIL oor_valid_%0d: got %0b want 1", c, ivld5); end
        n_cmp++; if (ivals5 !== e) begin n_bad++; $display("FAIL oor_vals_%0d: got %h want %h", c, ivals5, e); end
      end else begin
        n_cmp++; if (ivld5 !== 1'b0) begin n_bad++; $display("FAIL oor_idle_%0d: got %0b want 0", c, ivld5); end
      end
    end
    rv5 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rc, ed, rs;
    drive_load(0, 1'b0, 5, rc, ed, rs);
    rst = 1'b1; sval = 1'b1;
    @(negedge clk);
    rst = 1'b0; sval = 1'b0;
    n_cmp++; if (srdy !== 1'b0) begin n_bad++; $display("FAIL rstload_s_ready: got %0b want 0", srdy); end
    n_cmp++; if (iload !== 1'b0) begin n_bad++; $display("FAIL rstload_ir_loaded: got %0b want 0", iload); end
    n_cmp++; if (ivals !== 128'd0) begin n_bad++; $display("FAIL rstload_ir_vals: got %h want 0", ivals); end
    drive_load(0, 1'b0, 16, rc, ed, rs);
    rv = 1'b1; ra = 2'd0; rb = 2'd1;
    @(negedge clk);
    @(negedge clk);
    rv = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL rstread_ir_valid: got %0b want 0", ivld); end
    n_cmp++; if (ivals !== 128'd0) begin n_bad++; $display("FAIL rstread_ir_vals: got %h want 0", ivals); end
    n_cmp++; if (ldone !== 1'b0) begin n_bad++; $display("FAIL rstread_load_done: got %0b want 0", ldone); end
    n_cmp++; if (iload !== 1'b0) begin n_bad++; $display("FAIL rstread_ir_loaded: got %0b want 0", iload); end
    // back in EMPTY: reads must stay blocked and nothing in flight may surface
    rv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (ivld !== 1'b0) begin n_bad++; $display("FAIL rstread_stray_%0d: got %0b want 0", c, ivld); end
    end
    rv = 1'b0;
  endtask

  initial begin
    last_vec = '0;
    test_reset();
    test_reads_blocked_empty();
    test_full_load();
    test_reads_blocked_loading();
    test_gaps();
    test_restart();
    test_stream();
    test_out_of_range();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
